// File: rtl/edp_vector_sequencer.sv
// edp_vector_sequencer
//   EDP self-test sequencer. Plays a table of per-step stimulus (cache data
//   word + control word) into the EBOX data path. After each step it waits a
//   programmable settle time, then compares the observed AR against an
//   expected value under a mask. It reports pass/fail counts and the first
//   failing step.
// Ports
//   eboxClk, eboxReset   clock (posedge), asynchronous active-high reset
//   tblWe/tblAdr/tblStim/tblCtl/tblExp/tblMask
//                        table write port, honoured only while not busy
//   stepCount, loop      run length (0 = no-op) and rerun flag, sampled at start
//   start, abort         run control
//   EDP_AR               observed AR from edp
//   cacheDataRead, stimCtl, stimValid
//                        stimulus to edp, one stimValid strobe per step
//   busy, done           run in progress / one-cycle end-of-run pulse
//   errCount, firstFail, failed, passCount
//                        run results, held until the next start
module edp_vector_sequencer #(
  parameter int unsigned WIDTH   = 36,
  parameter int unsigned CTLW    = 24,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ERRW    = 8
) (
  input  logic                     eboxClk,
  input  logic                     eboxReset,
  input  logic                     tblWe,
  input  logic [$clog2(DEPTH)-1:0] tblAdr,
  input  logic [WIDTH-1:0]         tblStim,
  input  logic [CTLW-1:0]          tblCtl,
  input  logic [WIDTH-1:0]         tblExp,
  input  logic [WIDTH-1:0]         tblMask,
  input  logic [$clog2(DEPTH):0]   stepCount,
  input  logic                     start,
  input  logic                     loop,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         EDP_AR,
  output logic [WIDTH-1:0]         cacheDataRead,
  output logic [CTLW-1:0]          stimCtl,
  output logic                     stimValid,
  output logic                     busy,
  output logic                     done,
  output logic [ERRW-1:0]          errCount,
  output logic [$clog2(DEPTH)-1:0] firstFail,
  output logic                     failed,
  output logic [15:0]              passCount
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] SETTLE_INIT = 4'(LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

  logic [WIDTH-1:0] r_stimMem [DEPTH];
  logic [CTLW-1:0]  r_ctlMem  [DEPTH];
  logic [WIDTH-1:0] r_expMem  [DEPTH];
  logic [WIDTH-1:0] r_maskMem [DEPTH];

  state_t           r_state;
  logic [AW-1:0]    r_step;
  logic [AW:0]      r_count;
  logic             r_loop;
  logic [3:0]       r_settle;
  logic [WIDTH-1:0] r_data;
  logic [CTLW-1:0]  r_ctl;
  logic             r_stimValid;
  logic             r_busy;
  logic             r_done;
  logic [ERRW-1:0]  r_errCount;
  logic [AW-1:0]    r_firstFail;
  logic             r_failed;
  logic [15:0]      r_passCount;

  logic             w_mismatch;
  logic [AW:0]      w_stepInc;
  logic             w_more;
  logic [AW-1:0]    w_nextIdx;

  // Table is deliberately not reset; writes are locked out while a run is active.
  always_ff @(posedge eboxClk) begin
    if (tblWe && !r_busy) begin
      r_stimMem[tblAdr] <= tblStim;
      r_ctlMem[tblAdr]  <= tblCtl;
      r_expMem[tblAdr]  <= tblExp;
      r_maskMem[tblAdr] <= tblMask;
    end
  end

  assign w_mismatch = |((EDP_AR ^ r_expMem[r_step]) & r_maskMem[r_step]);
  assign w_stepInc  = {1'b0, r_step} + 1'b1;
  assign w_more     = (w_stepInc < r_count);
  // Step after CHECK: the next entry, or entry 0 when a looping run wraps.
  assign w_nextIdx  = w_more ? w_stepInc[AW-1:0] : '0;

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_count     <= '0;
      r_loop      <= 1'b0;
      r_settle    <= '0;
      r_data      <= '0;
      r_ctl       <= '0;
      r_stimValid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_errCount  <= '0;
      r_firstFail <= '0;
      r_failed    <= 1'b0;
      r_passCount <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            if (stepCount != '0) begin
              r_errCount  <= '0;
              r_failed    <= 1'b0;
              r_firstFail <= '0;
              r_passCount <= '0;
              r_step      <= '0;
              r_count     <= stepCount;
              r_loop      <= loop;
              r_busy      <= 1'b1;
              r_data      <= r_stimMem[0];
              r_ctl       <= r_ctlMem[0];
              r_stimValid <= 1'b1;
              r_state     <= S_DRIVE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_DRIVE: begin
          r_stimValid <= 1'b0;
          r_ctl       <= '0;
          if (abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (LATENCY == 1) begin
            r_state <= S_CHECK;
          end else begin
            r_settle <= SETTLE_INIT;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_settle <= 4'd1) begin
            r_state <= S_CHECK;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        S_CHECK: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (w_mismatch) begin
              if (r_errCount != '1) r_errCount <= r_errCount + 1'b1;
              if (!r_failed) r_firstFail <= r_step;
              r_failed <= 1'b1;
            end
            if (!w_more) r_passCount <= r_passCount + 16'd1;
            if (w_more || r_loop) begin
              r_step      <= w_nextIdx;
              r_data      <= r_stimMem[w_nextIdx];
              r_ctl       <= r_ctlMem[w_nextIdx];
              r_stimValid <= 1'b1;
              r_state     <= S_DRIVE;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cacheDataRead = r_data;
  assign stimCtl       = r_ctl;
  assign stimValid     = r_stimValid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign errCount      = r_errCount;
  assign firstFail     = r_firstFail;
  assign failed        = r_failed;
  assign passCount     = r_passCount;
endmodule
